// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master: one command in, one AXI-Lite read or write out, one response back.
// Optional watchdog (to_err, TIMEOUT_CYCLES) is built only when AXIL_CMD_MASTER_TIMEOUT_EN is defined.
module axil_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] PROT = 3'b000
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  output logic                  to_err,
`endif
  output logic [2:0]            dbg_state
);

  // Every channel transfers on a cycle where its valid and ready are both high at
  // the rising edge; a valid, once raised, stays high until that transfer happens.
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  write_q;
  logic                  aw_done, w_done;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  aw_fire, w_fire;

  assign aw_fire = m_axil_awvalid && m_axil_awready;
  assign w_fire  = m_axil_wvalid && m_axil_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WR_RESP;
      WR_RESP: if (m_axil_bvalid) state_next = RSP;
      RD_REQ:  if (m_axil_arready) state_next = RD_RESP;
      RD_RESP: if (m_axil_rvalid) state_next = RSP;
      RSP:     if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = (state == IDLE) && !rst;
    m_axil_awvalid = (state == WR_REQ) && !aw_done;
    m_axil_wvalid  = (state == WR_REQ) && !w_done;
    m_axil_bready  = (state == WR_RESP);
    m_axil_arvalid = (state == RD_REQ);
    m_axil_rready  = (state == RD_RESP);
    rsp_valid      = (state == RSP);
    dbg_state      = state;
  end

  assign m_axil_awaddr = addr_q;
  assign m_axil_araddr = addr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_wstrb  = wstrb_q;
  assign m_axil_awprot = PROT;
  assign m_axil_arprot = PROT;
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
          wstrb_q <= cmd_wstrb;
          write_q <= cmd_write;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        WR_REQ: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        WR_RESP: if (m_axil_bvalid) begin
          rdata_q <= '0;
          resp_q  <= m_axil_bresp;
        end
        RD_RESP: if (m_axil_rvalid) begin
          rdata_q <= m_axil_rdata;
          resp_q  <= m_axil_rresp;
        end
        default: ;
      endcase
    end
  end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  // Watchdog only flags a stall; the FSM keeps waiting on the slave.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             busy;

  assign busy = (state != IDLE) && (state != RSP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (state != state_next) begin
      to_cnt <= '0;
    end else if (busy) begin
      if (to_cnt != CNT_W'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
      if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) to_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: small AXI-Lite slave model with programmable stalls,
// cycle-exact checks against hand-computed timing; watchdog case only with AXIL_CMD_MASTER_TIMEOUT_EN.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot, dbg_state;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  logic        to_err;
`endif

  axil_cmd_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .PROT(3'b010)
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready),
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    .to_err(to_err),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int unsigned aw_wait = 0, w_wait = 0, aw_cnt, w_cnt;
  logic        b_en = 1'b1, r_en = 1'b1;
  logic [1:0]  rresp_cfg = 2'b00;
  logic        aw_got, w_got, b_pend, aw_now, w_now;
  logic [15:0] aw_addr_s, wa;
  logic [31:0] w_data_s, wd;
  logic [3:0]  w_strb_s, ws;
  logic [31:0] mem [0:255];

  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign arready = arvalid;
  assign bresp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; b_pend <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= '0;
    end else begin
      aw_now = aw_got || (awvalid && awready);
      w_now  = w_got || (wvalid && wready);
      wa = (awvalid && awready) ? awaddr : aw_addr_s;
      wd = (wvalid && wready) ? wdata : w_data_s;
      ws = (wvalid && wready) ? wstrb : w_strb_s;
      if (awvalid && awready) begin aw_cnt <= 0; aw_addr_s <= awaddr; end
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin w_cnt <= 0; w_data_s <= wdata; w_strb_s <= wstrb; end
      else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      else if (b_pend && b_en) begin bvalid <= 1'b1; b_pend <= 1'b0; end
      if (aw_now && w_now) begin
        for (int i = 0; i < 4; i++) if (ws[i]) mem[wa[9:2]][8*i +: 8] <= wd[8*i +: 8];
        aw_got <= 1'b0; w_got <= 1'b0;
        if (b_en) bvalid <= 1'b1; else b_pend <= 1'b1;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
      if (arvalid && arready) begin
        if (r_en) rvalid <= 1'b1;
        rdata <= mem[araddr[9:2]];
        rresp <= rresp_cfg;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Returns just after the accepting edge N; the next negedge samples cycle N+1.
  task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp(output logic wr, output logic [31:0] d, output logic [1:0] r);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
    wr = rsp_write; d = rsp_rdata; r = rsp_resp;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  logic        t_wr;
  logic [31:0] t_d;
  logic [1:0]  t_r;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #2;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
    chk("rst_awaddr", {16'd0, awaddr}, 32'd0);
    chk("rst_prot", {26'd0, awprot, arprot}, {26'd0, 3'b010, 3'b010});
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // zero-wait write
    send_cmd(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("wr_n1_aw_w", {30'd0, awvalid, wvalid}, 32'd3);
    chk("wr_n1_awaddr", {16'd0, awaddr}, 32'h0010);
    chk("wr_n1_wdata", wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_n2_aw_w_b_rsp", {28'd0, awvalid, wvalid, bready, rsp_valid}, 32'b0010);
    @(negedge clk);
    chk("wr_n3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_rsp_fields", {rsp_write, 29'd0, rsp_resp}, 32'h8000_0000);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("wr_after_rsp_cmd_ready", {30'd0, cmd_ready, rsp_valid}, 32'b10);

    // zero-wait read-back
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd_n1_arvalid", {29'd0, arvalid, awvalid, wvalid}, 32'b100);
    chk("rd_n1_araddr", {16'd0, araddr}, 32'h0010);
    @(negedge clk);
    chk("rd_n2_rready", {29'd0, arvalid, rready, rsp_valid}, 32'b010);
    @(negedge clk);
    chk("rd_n3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, exp_q.pop_front());
    chk("rd_rsp_fields", {rsp_write, 29'd0, rsp_resp}, 32'd0);
    finish_rsp(t_wr, t_d, t_r);

    // awready delayed 3 cycles, wready immediate
    aw_wait = 3;
    send_cmd(1'b1, 16'h0024, 32'hA5A5_0F0F, 4'hF);
    @(negedge clk);
    chk("awdly_n1", {29'd0, awvalid, wvalid, bready}, 32'b110);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("awdly_n%0d", k), {29'd0, awvalid, wvalid, bready}, 32'b100);
    end
    @(negedge clk);
    chk("awdly_n5", {29'd0, awvalid, wvalid, bready}, 32'b001);
    finish_rsp(t_wr, t_d, t_r);
    chk("awdly_rsp", {t_wr, 29'd0, t_r}, 32'h8000_0000);
    aw_wait = 0;

    // read with SLVERR and response back-pressure
    rresp_cfg = 2'b10;
    send_cmd(1'b0, 16'h0024, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid_ready", k), {30'd0, rsp_valid, cmd_ready}, 32'b10);
      chk($sformatf("bp_hold%0d_rdata", k), rsp_rdata, 32'hA5A5_0F0F);
      chk($sformatf("bp_hold%0d_resp", k), {30'd0, rsp_resp}, 32'd2);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_cmd_ready", {30'd0, cmd_ready, rsp_valid}, 32'b10);
    rresp_cfg = 2'b00;

    // reset while waiting in RD_RESP
    r_en = 1'b0;
    send_cmd(1'b0, 16'h0010, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    chk("rst_mid_rready", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {28'd0, arvalid, rready, rsp_valid, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    r_en = 1'b1;
    send_cmd(1'b1, 16'h0040, 32'h1234_5678, 4'hF);
    finish_rsp(t_wr, t_d, t_r);
    chk("post_rst_wr_rsp", {t_wr, 29'd0, t_r}, 32'h8000_0000);
    send_cmd(1'b0, 16'h0040, 32'h0, 4'h0);
    finish_rsp(t_wr, t_d, t_r);
    chk("post_rst_rd_data", t_d, 32'h1234_5678);

    // partial strobe write merges bytes
    send_cmd(1'b1, 16'h0040, 32'hFFFF_FFFF, 4'b0101);
    finish_rsp(t_wr, t_d, t_r);
    send_cmd(1'b0, 16'h0040, 32'h0, 4'h0);
    finish_rsp(t_wr, t_d, t_r);
    chk("strb_merge", t_d, 32'h12FF_56FF);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // watchdog: bvalid withheld
    b_en = 1'b0;
    send_cmd(1'b1, 16'h0050, 32'h0000_0001, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("to_enter_wr_resp", {30'd0, bready, to_err}, 32'b10);
    repeat (8) @(negedge clk);
    chk("to_not_yet", {31'd0, to_err}, 32'd0);
    repeat (12) @(negedge clk);
    chk("to_set", {30'd0, bready, to_err}, 32'b11);
    b_en = 1'b1;
    finish_rsp(t_wr, t_d, t_r);
    chk("to_late_rsp", {t_wr, 29'd0, t_r}, 32'h8000_0000);
    @(negedge clk);
    chk("to_sticky", {31'd0, to_err}, 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
